// File: rtl/led_status_tx_pkg.sv
// Shared constants and FSM encoding for the LED status TX block and its RX counterpart.
// The frame is a 0x55 header followed by the 64-bit status word, MSB byte first.
package led_status_tx_pkg;

    localparam logic [7:0] HDR_BYTE       = 8'h55;
    localparam int         PAYLOAD_BYTES  = 8;
    localparam int         FRAME_LEN_BASE = 9;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SEND,
        GAP
    } state_t;

    // Payload byte idx (0 = first on the wire) taken from a 64-bit status word.
    function automatic logic [7:0] payload_byte(input logic [63:0] word, input int idx);
        return word[63 - 8*idx -: 8];
    endfunction

endpackage

// File: rtl/led_tx_period_timer.sv
// Free-running auto-send timer: counts 0..PERIOD_CYCLES-1 and ticks on the wrap cycle.
// PERIOD_CYCLES = 0 holds the counter at 0 and never ticks.
module led_tx_period_timer #(
    parameter int unsigned PERIOD_CYCLES = 0
) (
    input  logic udp_tx_clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned   CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = (PERIOD_CYCLES > 0) ? CNT_W'(PERIOD_CYCLES - 1) : '0;

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge udp_tx_clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (PERIOD_CYCLES == 0 || count_reg == LAST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tick = (PERIOD_CYCLES != 0) && (count_reg == LAST);

endmodule

// File: rtl/led_status_tx.sv
// LED status frame transmitter: snapshots status_word, arbitrates for the UDP TX path and
// streams header + 8 payload bytes. Define LED_TX_CSUM_EN to append an XOR checksum byte.
module led_status_tx #(
    parameter int unsigned PERIOD_CYCLES = 0,
    parameter int unsigned IFG_CYCLES    = 4
) (
    input  logic        udp_tx_clk,
    input  logic        reset,
    input  logic [63:0] status_word,
    input  logic        send_req,
    output logic        app_tx_data_request,
    input  logic        app_tx_ack,
    output logic        app_tx_data_valid,
    output logic [7:0]  app_tx_data,
    output logic [15:0] app_tx_data_length,
    output logic        busy
);

    import led_status_tx_pkg::*;

`ifdef LED_TX_CSUM_EN
    localparam int FRAME_LEN = FRAME_LEN_BASE + 1;
`else
    localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif
    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);
    localparam logic [7:0] IFG_LAST = 8'(IFG_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [3:0]  byte_idx_reg, byte_idx_next;
    logic [7:0]  gap_cnt_reg, gap_cnt_next;
    logic        pending_reg, pending_next;
    logic [63:0] snap_reg, snap_next;
    logic        tick;
    logic        trigger;
    logic [7:0]  frame_bytes [FRAME_LEN];

    led_tx_period_timer #(
        .PERIOD_CYCLES(PERIOD_CYCLES)
    ) u_timer (
        .udp_tx_clk(udp_tx_clk),
        .reset     (reset),
        .tick      (tick)
    );

    assign frame_bytes[0] = HDR_BYTE;
    generate
        for (genvar gi = 0; gi < PAYLOAD_BYTES; gi++) begin : g_payload
            assign frame_bytes[gi + 1] = payload_byte(snap_reg, gi);
        end
    endgenerate

`ifdef LED_TX_CSUM_EN
    logic [7:0] csum;
    always_comb begin
        csum = '0;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            csum = csum ^ payload_byte(snap_reg, i);
        end
    end
    assign frame_bytes[FRAME_LEN - 1] = csum;
`endif

    assign trigger = send_req | pending_reg | tick;

    always_ff @(posedge udp_tx_clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            byte_idx_reg <= '0;
            gap_cnt_reg  <= '0;
            pending_reg  <= 1'b0;
            snap_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            byte_idx_reg <= byte_idx_next;
            gap_cnt_reg  <= gap_cnt_next;
            pending_reg  <= pending_next;
            snap_reg     <= snap_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        byte_idx_next = byte_idx_reg;
        gap_cnt_next  = gap_cnt_reg;
        pending_next  = pending_reg;
        snap_next     = snap_reg;
        case (state_reg)
            IDLE: begin
                // Entering REQ consumes every trigger present this cycle.
                if (trigger) begin
                    state_next   = REQ;
                    snap_next    = status_word;
                    pending_next = 1'b0;
                end
            end
            REQ: begin
                if (app_tx_ack) begin
                    state_next    = SEND;
                    byte_idx_next = '0;
                end
            end
            SEND: begin
                if (byte_idx_reg == LAST_IDX) begin
                    state_next   = GAP;
                    gap_cnt_next = '0;
                end else begin
                    byte_idx_next = byte_idx_reg + 4'd1;
                end
            end
            GAP: begin
                if (gap_cnt_reg == IFG_LAST) begin
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (state_reg != IDLE && (send_req || tick)) begin
            pending_next = 1'b1;
        end
    end

    assign app_tx_data_request = (state_reg == REQ);
    assign app_tx_data_valid   = (state_reg == SEND);
    assign app_tx_data         = app_tx_data_valid ? frame_bytes[byte_idx_reg] : 8'h00;
    assign app_tx_data_length  = app_tx_data_request ? 16'(FRAME_LEN) : 16'h0000;
    assign busy                = (state_reg != IDLE);

endmodule

// File: tb/tb_led_status_tx.sv
// Self-checking bench for led_status_tx: a monitor collects frames and request edges, and
// each test compares them against a frame model built from the status word.
`timescale 1ns/1ps
module tb_led_status_tx;

    localparam int IFG = 4;
`ifdef LED_TX_CSUM_EN
    localparam int FL = 10;
`else
    localparam int FL = 9;
`endif

    typedef struct {
        logic [79:0] data;
        int          n;
        int          first;
        int          last;
    } frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT a: explicit requests only
    logic        rst_a = 1'b1;
    logic [63:0] status_a = '0;
    logic        send_a = 1'b0;
    logic        req_a, ack_a, valid_a, busy_a;
    logic [7:0]  data_a;
    logic [15:0] len_a;

    // DUT b: periodic auto-send every 100 cycles
    logic        rst_b = 1'b1;
    logic [63:0] status_b = 64'hA5A5_0000_1234_5678;
    logic        send_b = 1'b0;
    logic        req_b, ack_b, valid_b, busy_b;
    logic [7:0]  data_b;
    logic [15:0] len_b;

    led_status_tx #(.PERIOD_CYCLES(0), .IFG_CYCLES(IFG)) dut_a (
        .udp_tx_clk         (clk),
        .reset              (rst_a),
        .status_word        (status_a),
        .send_req           (send_a),
        .app_tx_data_request(req_a),
        .app_tx_ack         (ack_a),
        .app_tx_data_valid  (valid_a),
        .app_tx_data        (data_a),
        .app_tx_data_length (len_a),
        .busy               (busy_a)
    );

    led_status_tx #(.PERIOD_CYCLES(100), .IFG_CYCLES(IFG)) dut_b (
        .udp_tx_clk         (clk),
        .reset              (rst_b),
        .status_word        (status_b),
        .send_req           (send_b),
        .app_tx_data_request(req_b),
        .app_tx_ack         (ack_b),
        .app_tx_data_valid  (valid_b),
        .app_tx_data        (data_b),
        .app_tx_data_length (len_b),
        .busy               (busy_b)
    );

    int checks = 0;
    int failures = 0;

    frame_t      frames_a[$];
    int          rises_a[$];
    int          lens_a[$];
    int          busy_falls_a[$];
    int          rises_b[$];
    int          cur_n_a = 0;
    logic [79:0] cur_d_a = '0;
    int          cur_first_a = 0;
    int          idle_data_bad = 0;
    int          ack_delay_a = 0;
    logic        force_ack_a = 1'b0;

    // Reference frame: header, status bytes MSB first, optional XOR of the payload.
    function automatic logic [79:0] model_frame(input logic [63:0] s);
        logic [79:0] f;
        logic [7:0]  b;
        logic [7:0]  x;
        f = '0;
        x = '0;
        f[79:72] = 8'h55;
        for (int k = 0; k < 8; k++) begin
            b = 8'(s >> (56 - 8*k));
            f[71 - 8*k -: 8] = b;
            x = x ^ b;
        end
        if (FL == 10) f[7:0] = x;
        return f;
    endfunction

    initial begin : mon_a
        logic pv, pr, pb;
        pv = 1'b0; pr = 1'b0; pb = 1'b0;
        forever begin
            @(negedge clk);
            if (req_a && !pr) begin
                rises_a.push_back(cyc);
                lens_a.push_back(int'(len_a));
            end
            if (!busy_a && pb) busy_falls_a.push_back(cyc);
            if (valid_a) begin
                if (!pv) begin
                    cur_n_a = 0;
                    cur_d_a = '0;
                    cur_first_a = cyc;
                end
                if (cur_n_a < 10) cur_d_a[79 - 8*cur_n_a -: 8] = data_a;
                cur_n_a++;
            end else begin
                if (data_a !== 8'h00) idle_data_bad++;
                if (pv) frames_a.push_back('{cur_d_a, cur_n_a, cur_first_a, cyc - 1});
            end
            pv = valid_a; pr = req_a; pb = busy_a;
        end
    end

    initial begin : mon_b
        logic pr;
        pr = 1'b0;
        forever begin
            @(negedge clk);
            if (req_b && !pr) rises_b.push_back(cyc);
            pr = req_b;
        end
    end

    initial begin : ack_resp_a
        int w;
        w = 0;
        ack_a = 1'b0;
        forever begin
            @(negedge clk);
            if (req_a) begin
                ack_a = (w == ack_delay_a);
                w++;
            end else begin
                ack_a = 1'b0;
                w = 0;
            end
            if (force_ack_a) ack_a = 1'b1;
        end
    end

    initial begin : ack_resp_b
        ack_b = 1'b0;
        forever begin
            @(negedge clk);
            ack_b = req_b;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_send_a();
        send_a = 1'b1;
        step();
        send_a = 1'b0;
    endtask

    task automatic wait_frames_a(input int target, input int budget, output bit ok);
        for (int i = 0; i < budget && frames_a.size() < target; i++) step();
        ok = (frames_a.size() >= target);
    endtask

    task automatic wait_valid_a(input int budget, output bit ok);
        for (int i = 0; i < budget && !valid_a; i++) step();
        ok = valid_a;
    endtask

    task automatic wait_idle_a(input int budget, output bit ok);
        for (int i = 0; i < budget && busy_a; i++) step();
        ok = !busy_a;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (3) step();
        checks++;
        if ({req_a, valid_a, busy_a} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl actual=%b required=000", {req_a, valid_a, busy_a});
        end
        checks++;
        if (data_a !== 8'h00 || len_a !== 16'h0000) begin
            failures++;
            $display("FAIL reset_data actual=%h/%h required=00/0000", data_a, len_a);
        end
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (3) step();
        checks++;
        if (busy_a !== 1'b0 || req_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle actual=busy%b req%b required=busy0 req0", busy_a, req_a);
        end
    endtask

    task automatic test_basic();
        int nf, nr, nb, n0;
        bit ok;
        frame_t f;
        status_a = 64'h0123_4567_89AB_CDEF;
        ack_delay_a = 2;
        nf = frames_a.size(); nr = rises_a.size(); nb = busy_falls_a.size();
        n0 = cyc;
        pulse_send_a();
        wait_frames_a(nf + 1, 100, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL basic_timeout actual=no_frame required=frame");
            return;
        end
        wait_idle_a(50, ok);
        f = frames_a[nf];
        checks++;
        if (rises_a[nr] !== n0 + 1) begin
            failures++;
            $display("FAIL basic_req_latency actual=%0d required=%0d", rises_a[nr], n0 + 1);
        end
        checks++;
        if (lens_a[nr] !== FL) begin
            failures++;
            $display("FAIL basic_length actual=%0d required=%0d", lens_a[nr], FL);
        end
        checks++;
        if (f.n !== FL || f.data !== model_frame(status_a)) begin
            failures++;
            $display("FAIL basic_frame actual=%0d:%h required=%0d:%h", f.n, f.data, FL, model_frame(status_a));
        end
        checks++;
        if (f.first !== n0 + 4) begin
            failures++;
            $display("FAIL basic_first_byte actual=%0d required=%0d", f.first, n0 + 4);
        end
        checks++;
        if (busy_falls_a.size() <= nb || busy_falls_a[nb] !== f.last + IFG + 1) begin
            failures++;
            $display("FAIL basic_busy_fall actual=%0d required=%0d",
                     (busy_falls_a.size() > nb) ? busy_falls_a[nb] : -1, f.last + IFG + 1);
        end
    endtask

    task automatic test_snapshot();
        logic [63:0] s;
        int nf;
        bit ok;
        s = {$urandom, $urandom};
        status_a = s;
        ack_delay_a = int'($urandom_range(0, 3));
        nf = frames_a.size();
        pulse_send_a();
        wait_valid_a(50, ok);
        status_a = '1;
        wait_frames_a(nf + 1, 50, ok);
        checks++;
        if (!ok || frames_a[nf].data !== model_frame(s)) begin
            failures++;
            $display("FAIL snapshot_hold actual=%h required=%h", ok ? frames_a[nf].data : '0, model_frame(s));
        end
        wait_idle_a(50, ok);
        pulse_send_a();
        wait_frames_a(nf + 2, 60, ok);
        checks++;
        if (!ok || frames_a[nf + 1].data !== model_frame('1)) begin
            failures++;
            $display("FAIL snapshot_next actual=%h required=%h", ok ? frames_a[nf + 1].data : '0, model_frame('1));
        end
        wait_idle_a(50, ok);
    endtask

    task automatic test_pending_merge();
        logic [63:0] s;
        int nf, nr;
        bit ok;
        s = {$urandom, $urandom};
        status_a = s;
        ack_delay_a = int'($urandom_range(0, 3));
        nf = frames_a.size(); nr = rises_a.size();
        pulse_send_a();
        wait_valid_a(50, ok);
        step();
        pulse_send_a(); step();
        pulse_send_a(); step();
        pulse_send_a();
        wait_frames_a(nf + 2, 200, ok);
        repeat (60) step();
        checks++;
        if (frames_a.size() !== nf + 2 || rises_a.size() !== nr + 2) begin
            failures++;
            $display("FAIL pending_count actual=%0d required=%0d", frames_a.size() - nf, 2);
            return;
        end
        checks++;
        if (rises_a[nr + 1] !== frames_a[nf].last + IFG + 2) begin
            failures++;
            $display("FAIL pending_req_time actual=%0d required=%0d", rises_a[nr + 1], frames_a[nf].last + IFG + 2);
        end
        checks++;
        if (frames_a[nf + 1].data !== model_frame(s) || frames_a[nf + 1].n !== FL) begin
            failures++;
            $display("FAIL pending_frame actual=%h required=%h", frames_a[nf + 1].data, model_frame(s));
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int prev_last, n0, nf, nr, d, exp_rise;
        ok = 1'b1;
        wait_idle_a(50, ok);
        prev_last = -100;
        for (int it = 0; it < 6; it++) begin
            status_a = {$urandom, $urandom};
            d = int'($urandom_range(0, 4));
            ack_delay_a = d;
            nf = frames_a.size(); nr = rises_a.size();
            n0 = cyc;
            pulse_send_a();
            wait_frames_a(nf + 1, 100, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL b2b_timeout iter=%0d actual=no_frame required=frame", it);
                return;
            end
            exp_rise = (n0 + 1 > prev_last + IFG + 2) ? n0 + 1 : prev_last + IFG + 2;
            checks++;
            if (rises_a[nr] !== exp_rise || frames_a[nf].first !== exp_rise + d + 1) begin
                failures++;
                $display("FAIL b2b_timing iter=%0d actual=%0d/%0d required=%0d/%0d", it,
                         rises_a[nr], frames_a[nf].first, exp_rise, exp_rise + d + 1);
            end
            checks++;
            if (frames_a[nf].data !== model_frame(status_a) || frames_a[nf].n !== FL) begin
                failures++;
                $display("FAIL b2b_frame iter=%0d actual=%h required=%h", it, frames_a[nf].data, model_frame(status_a));
            end
            prev_last = frames_a[nf].last;
            repeat ($urandom_range(0, 8)) step();
        end
        wait_idle_a(50, ok);
    endtask

    task automatic test_ack_outside_req();
        int nr;
        bit ok;
        wait_idle_a(50, ok);
        nr = rises_a.size();
        force_ack_a = 1'b1;
        repeat (3) step();
        force_ack_a = 1'b0;
        repeat (3) step();
        checks++;
        if (rises_a.size() !== nr || busy_a !== 1'b0 || valid_a !== 1'b0) begin
            failures++;
            $display("FAIL stray_ack actual=rises%0d busy%b required=rises0 busy0", rises_a.size() - nr, busy_a);
        end
    endtask

    task automatic test_reset_mid_frame();
        int nr, nf;
        bit ok;
        status_a = {$urandom, $urandom};
        ack_delay_a = 1;
        nf = frames_a.size();
        pulse_send_a();
        wait_valid_a(50, ok);
        pulse_send_a();
        for (int i = 0; i < 20 && cur_n_a != 5; i++) step();
        #2 rst_a = 1'b1;
        #1;
        checks++;
        if ({req_a, valid_a, busy_a} !== 3'b000 || data_a !== 8'h00 || len_a !== 16'h0000) begin
            failures++;
            $display("FAIL reset_async actual=%b/%h/%h required=000/00/0000", {req_a, valid_a, busy_a}, data_a, len_a);
        end
        repeat (2) step();
        rst_a = 1'b0;
        nr = rises_a.size();
        repeat (40) step();
        checks++;
        if (rises_a.size() !== nr || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_pending_cleared actual=rises%0d busy%b required=rises0 busy0", rises_a.size() - nr, busy_a);
        end
        checks++;
        if (frames_a.size() !== nf + 1 || frames_a[frames_a.size() - 1].n !== 5) begin
            failures++;
            $display("FAIL reset_trailing actual=%0d required=5", frames_a[frames_a.size() - 1].n);
        end
    endtask

    task automatic test_checksum_pattern();
        int nf, nr;
        bit ok;
        logic [79:0] exp;
        status_a = 64'h0102_0408_1020_4080;
        ack_delay_a = 0;
        exp = model_frame(status_a);
        nf = frames_a.size(); nr = rises_a.size();
        pulse_send_a();
        wait_frames_a(nf + 1, 60, ok);
        checks++;
        if (!ok || frames_a[nf].data !== exp || frames_a[nf].n !== FL || lens_a[nr] !== FL) begin
            failures++;
            $display("FAIL csum_frame actual=%h required=%h", ok ? frames_a[nf].data : '0, exp);
        end
        wait_idle_a(50, ok);
    endtask

    task automatic test_periodic();
        int k0, r;
        int after[$];
        k0 = rises_b.size();
        for (int i = 0; i < 600 && rises_b.size() < k0 + 4; i++) step();
        checks++;
        if (rises_b.size() < k0 + 4) begin
            failures++;
            $display("FAIL periodic_timeout actual=%0d required=4", rises_b.size() - k0);
            return;
        end
        for (int j = 1; j < 4; j++) begin
            checks++;
            if (rises_b[k0 + j] - rises_b[k0 + j - 1] !== 100) begin
                failures++;
                $display("FAIL periodic_interval actual=%0d required=100", rises_b[k0 + j] - rises_b[k0 + j - 1]);
            end
        end
        r = rises_b[rises_b.size() - 1];
        for (int i = 0; i < 200 && cyc < r + 99; i++) step();
        send_b = 1'b1;
        step();
        send_b = 1'b0;
        for (int i = 0; i < 300 && cyc < r + 260; i++) step();
        foreach (rises_b[i]) if (rises_b[i] > r) after.push_back(rises_b[i]);
        checks++;
        if (after.size() !== 2 || after[0] !== r + 100 || after[1] !== r + 200) begin
            failures++;
            $display("FAIL periodic_coincident actual=n%0d first%0d required=n2 first%0d",
                     after.size(), (after.size() > 0) ? after[0] : -1, r + 100);
        end
    endtask

    task automatic test_idle_data();
        checks++;
        if (idle_data_bad !== 0) begin
            failures++;
            $display("FAIL idle_data_zero actual=%0d required=0", idle_data_bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_snapshot();
        test_pending_merge();
        test_back_to_back();
        test_ack_outside_req();
        test_checksum_pattern();
        test_reset_mid_frame();
        test_periodic();
        test_idle_data();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
